// File: rtl/tmds_encoder.sv
// TMDS 8b/10b channel encoder with DC balancing, two-clock pipeline (pixel clock domain).
// Optional HDMI data-island TERC4 coding is enabled by defining TMDS_TERC4_EN.
module tmds_encoder #(
   parameter int LATENCY = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       de,
   input  logic       c0,
   input  logic       c1,
   input  logic [7:0] data,
`ifdef TMDS_TERC4_EN
   input  logic       island,
   input  logic [3:0] aux,
`endif
   output logic [9:0] tmds,
   output logic       de_o
);

   generate
      if (LATENCY != 2) begin : g_bad_latency
         $error("tmds_encoder: LATENCY must be 2");
      end
   endgenerate

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] sum;
      sum = 4'd0;
      for (int i = 0; i < 8; i++) sum = sum + {3'b000, v[i]};
      return sum;
   endfunction

   // Transition-minimising stage: XNOR chain when the byte is ones-heavy.
   function automatic logic [8:0] minimise(input logic [7:0] d);
      logic [8:0] q;
      logic [3:0] n1d;
      logic       use_xnor;
      n1d      = popcount8(d);
      use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
      q[0]     = d[0];
      for (int i = 1; i < 8; i++)
         q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
      q[8] = ~use_xnor;
      return q;
   endfunction

`ifdef TMDS_TERC4_EN
   function automatic logic [9:0] terc4(input logic [3:0] a);
      logic [9:0] s;
      case (a)
         4'h0: s = 10'h29C;
         4'h1: s = 10'h263;
         4'h2: s = 10'h2E4;
         4'h3: s = 10'h2E2;
         4'h4: s = 10'h171;
         4'h5: s = 10'h11E;
         4'h6: s = 10'h18E;
         4'h7: s = 10'h13C;
         4'h8: s = 10'h2CC;
         4'h9: s = 10'h139;
         4'hA: s = 10'h19C;
         4'hB: s = 10'h2C6;
         4'hC: s = 10'h28E;
         4'hD: s = 10'h271;
         4'hE: s = 10'h163;
         default: s = 10'h2C3;
      endcase
      return s;
   endfunction
`endif

   logic [8:0] q_m_d;
   logic [8:0] s1_q_m;
   logic [3:0] s1_n1q;
   logic [3:0] s1_n0q;
   logic       s1_de;
   logic       s1_c0;
   logic       s1_c1;
`ifdef TMDS_TERC4_EN
   logic       s1_island;
   logic [3:0] s1_aux;
`endif

   assign q_m_d = minimise(data);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_q_m    <= 9'd0;
         s1_n1q    <= 4'd0;
         s1_n0q    <= 4'd0;
         s1_de     <= 1'b0;
         s1_c0     <= 1'b0;
         s1_c1     <= 1'b0;
`ifdef TMDS_TERC4_EN
         s1_island <= 1'b0;
         s1_aux    <= 4'd0;
`endif
      end else begin
         s1_q_m    <= q_m_d;
         s1_n1q    <= popcount8(q_m_d[7:0]);
         s1_n0q    <= 4'd8 - popcount8(q_m_d[7:0]);
         s1_de     <= de;
         s1_c0     <= c0;
         s1_c1     <= c1;
`ifdef TMDS_TERC4_EN
         s1_island <= island;
         s1_aux    <= aux;
`endif
      end
   end

   logic signed [4:0] cnt;
   logic signed [4:0] cnt_nxt;
   logic signed [4:0] diff;
   logic signed [4:0] two_qm8;
   logic signed [4:0] two_nqm8;
   logic [9:0]        tmds_nxt;
   logic              de_o_nxt;

   always_comb begin
      tmds_nxt = tmds;
      cnt_nxt  = cnt;
      de_o_nxt = s1_de;
      diff     = $signed({1'b0, s1_n1q}) - $signed({1'b0, s1_n0q});
      two_qm8  = $signed({3'b000, s1_q_m[8], 1'b0});
      two_nqm8 = $signed({3'b000, ~s1_q_m[8], 1'b0});
`ifdef TMDS_TERC4_EN
      if (s1_island) begin
         tmds_nxt = terc4(s1_aux);
         cnt_nxt  = 5'sd0;
         de_o_nxt = 1'b0;
      end else
`endif
      if (!s1_de) begin
         cnt_nxt = 5'sd0;
         case ({s1_c1, s1_c0})
            2'b00:   tmds_nxt = 10'h354;
            2'b01:   tmds_nxt = 10'h0AB;
            2'b10:   tmds_nxt = 10'h154;
            default: tmds_nxt = 10'h2AB;
         endcase
      end else if ((cnt == 5'sd0) || (diff == 5'sd0)) begin
         if (s1_q_m[8]) begin
            tmds_nxt = {2'b01, s1_q_m[7:0]};
            cnt_nxt  = cnt + diff;
         end else begin
            tmds_nxt = {2'b10, ~s1_q_m[7:0]};
            cnt_nxt  = cnt - diff;
         end
      end else if (((cnt > 5'sd0) && (diff > 5'sd0)) || ((cnt < 5'sd0) && (diff < 5'sd0))) begin
         tmds_nxt = {1'b1, s1_q_m[8], ~s1_q_m[7:0]};
         cnt_nxt  = cnt + two_qm8 - diff;
      end else begin
         tmds_nxt = {1'b0, s1_q_m[8], s1_q_m[7:0]};
         cnt_nxt  = cnt + diff - two_nqm8;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tmds <= 10'h354;
         de_o <= 1'b0;
         cnt  <= 5'sd0;
      end else begin
         tmds <= tmds_nxt;
         de_o <= de_o_nxt;
         cnt  <= cnt_nxt;
      end
   end

endmodule
